// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - prioritised stall/flush/redirect, trap entry and WFI sleep control
module pipeline_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall_i,
    input  logic        load_use_i,
    input  logic        branch_taken_i,
    input  logic        mret_i,
    input  logic        wfi_i,
    input  logic        irq_i,
    input  logic [31:0] id_pc_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  pc_sel_o,
    output logic        trap_take_o,
    output logic [31:0] epc_o,
    output logic        sleep_o
);

    localparam logic [1:0] FCNT_RESET    = 2'(FLUSH_CYCLES);
    localparam logic [1:0] FCNT_REDIRECT = 2'(FLUSH_CYCLES - 1);

    localparam logic [1:0] PC_SEL_SEQ   = 2'b00;
    localparam logic [1:0] PC_SEL_BR    = 2'b01;
    localparam logic [1:0] PC_SEL_MTVEC = 2'b10;
    localparam logic [1:0] PC_SEL_MEPC  = 2'b11;

    typedef enum logic [1:0] {
        S_RUN,
        S_IRQ_ACK,
        S_TRAP,
        S_SLEEP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [31:0] epc_q, epc_d;

    // Freezing front end while letting ID bubble out: common to irq, wfi, load-use and sleep.
    logic hold_front;

    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        pc_sel_o       = PC_SEL_SEQ;
        trap_take_o    = 1'b0;
        hold_front     = 1'b0;
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        epc_d          = epc_q;

        if (mem_stall_i) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_stall_o = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (fcnt_q != 2'd0) begin
                        // Fetch latency after a redirect: discard whatever IF returns.
                        if_id_flush_o = 1'b1;
                        fcnt_d        = fcnt_q - 2'd1;
                    end else if (branch_taken_i) begin
                        pc_sel_o      = PC_SEL_BR;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                        fcnt_d        = FCNT_REDIRECT;
                    end else if (irq_i) begin
                        hold_front = 1'b1;
                        epc_d      = id_pc_i;
                        state_d    = S_IRQ_ACK;
                    end else if (mret_i) begin
                        pc_sel_o      = PC_SEL_MEPC;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                        fcnt_d        = FCNT_REDIRECT;
                    end else if (wfi_i) begin
                        hold_front = 1'b1;
                        epc_d      = id_pc_i + 32'd4;
                        state_d    = S_SLEEP;
                    end else if (load_use_i) begin
                        hold_front = 1'b1;
                    end
                end
                S_IRQ_ACK: begin
                    hold_front = 1'b1;
                    state_d    = S_TRAP;
                end
                S_TRAP: begin
                    trap_take_o   = 1'b1;
                    pc_sel_o      = PC_SEL_MTVEC;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    fcnt_d        = FCNT_REDIRECT;
                    state_d       = S_RUN;
                end
                S_SLEEP: begin
                    hold_front = 1'b1;
                    if (irq_i) begin
                        state_d = S_TRAP;
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase

            if (hold_front) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            fcnt_q  <= FCNT_RESET;
            epc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            epc_q   <= epc_d;
        end
    end

    assign epc_o   = epc_q;
    assign sleep_o = (state_q == S_SLEEP);

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush/redirect sequencer for the five-stage RV32 core. It merges load-use hazards, memory-wrapper stalls, EX-stage branch/jump redirects, ID-stage `mret`/`wfi` and the masked external interrupt into one prioritised set of per-register stall and flush controls. It also drives the PC-source select, the WFI sleep state, trap entry and the exception PC. It sits beside the ID stage and replaces the scattered flush/stall glue around the hazard unit and CSR file.

## Interface
- `FLUSH_CYCLES`, default 2: number of consecutive cycles IF/ID is flushed after any redirect; legal 1..3. Covers instruction-memory latency.
- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `mem_stall_i`  in  1  IM/DM wrapper busy; freezes the whole pipeline
- `load_use_i`  in  1  load-use hazard from the hazard detection unit
- `branch_taken_i`  in  1  EX resolved a taken branch or jump
- `mret_i`  in  1  valid `mret` in ID
- `wfi_i`  in  1  valid `wfi` in ID
- `irq_i`  in  1  external interrupt, level, already masked by MIE/mie
- `id_pc_i`  in  32  PC of the instruction in ID
- `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_mem_stall_o`, `mem_wb_stall_o`  out  1 each  hold the register
- `if_id_flush_o`, `id_ex_flush_o`  out  1 each  load a bubble (all-zero instruction/controls)
- `pc_sel_o`  out  2  00 = PC+4, 01 = EX branch target, 10 = mtvec, 11 = mepc
- `trap_take_o`  out  1  one-cycle pulse; the CSR file writes mepc ← `epc_o` and updates mstatus
- `epc_o`  out  32  registered exception PC
- `sleep_o`  out  1  core is in WFI sleep

## Operation
- State: FSM {RUN, IRQ_ACK, TRAP, SLEEP}, a 2-bit counter `fcnt`, and the 32-bit `epc_o` register.
- Reset values: state RUN, `fcnt` = `FLUSH_CYCLES`, `epc_o` = 0. This gives a post-reset front-end flush.
- Outputs are combinational from state, `fcnt` and the inputs. Default value of every output is 0.
- `mem_stall_i` = 1, in any state:
  - all five stall outputs = 1; both flushes = 0; `pc_sel_o` = 00; `trap_take_o` = 0;
  - state, `fcnt` and `epc_o` hold;
  - `sleep_o` still reflects the state.
- RUN with `fcnt` > 0: `if_id_flush_o` = 1 and `fcnt` decrements. All other event inputs are ignored (ID and EX hold bubbles). `irq_i` stays pending because it is a level.
- RUN with `fcnt` = 0, events evaluated in priority order:
  1. `branch_taken_i`: `pc_sel_o` = 01, `if_id_flush_o` = 1, `id_ex_flush_o` = 1, `fcnt` ← `FLUSH_CYCLES`−1.
  2. `irq_i`: `pc_stall_o` = 1, `if_id_stall_o` = 1, `id_ex_flush_o` = 1, `epc_o` ← `id_pc_i`, go to IRQ_ACK.
  3. `mret_i`: `pc_sel_o` = 11, `if_id_flush_o` = 1, `id_ex_flush_o` = 1, `fcnt` ← `FLUSH_CYCLES`−1.
  4. `wfi_i`: `pc_stall_o` = 1, `if_id_stall_o` = 1, `id_ex_flush_o` = 1, `epc_o` ← `id_pc_i`+4 (mod 2^32), go to SLEEP.
  5. `load_use_i`: `pc_stall_o` = 1, `if_id_stall_o` = 1, `id_ex_flush_o` = 1; stay in RUN.
- IRQ_ACK: one cycle that lets older instructions retire. Outputs `pc_stall_o` = 1, `if_id_stall_o` = 1, `id_ex_flush_o` = 1; next state TRAP.
- TRAP: `trap_take_o` = 1, `pc_sel_o` = 10, `if_id_flush_o` = 1, `id_ex_flush_o` = 1, `fcnt` ← `FLUSH_CYCLES`−1; next state RUN.
- SLEEP: `sleep_o` = 1, `pc_stall_o` = 1, `if_id_stall_o` = 1, `id_ex_flush_o` = 1, so EX/MEM/WB drain.
  - `irq_i` = 1: next state TRAP. `epc_o` keeps the WFI PC+4.
- `rst` asserted mid-operation: immediately returns to the reset values. No `trap_take_o` is produced.

## Timing
- Branch redirect:
  - new PC is loaded on the edge ending the `branch_taken_i` cycle;
  - IF/ID is flushed for `FLUSH_CYCLES` consecutive cycles, the first being the `branch_taken_i` cycle;
  - ID/EX is flushed in the first cycle only.
- Interrupt from RUN: `irq_i` sampled high at cycle N (`fcnt` = 0, no stall, no branch) gives IRQ_ACK at N+1, TRAP with `trap_take_o` at N+2, and the mtvec fetch at N+3.
- Interrupt from SLEEP: `trap_take_o` is asserted in the cycle after `irq_i` is first seen high.
- Load-use: exactly one bubble per cycle that `load_use_i` is high.
- `mem_stall_i` stretches any state by its duration. No event is lost, since all events are levels re-presented by their sources.
- `epc_o` updates only on IRQ decision and WFI entry. It is stable while `trap_take_o` = 1.

## Test plan
- Reset release with `FLUSH_CYCLES` = 2 → `if_id_flush_o` = 1 for the 2 cycles after reset, then 0; `pc_sel_o` = 00; all stalls 0.
- `branch_taken_i` and `load_use_i` both high for 1 cycle → `pc_sel_o` = 01, both flushes = 1, no stalls; the next cycle has `if_id_flush_o` only; then idle.
- `irq_i` high with `id_pc_i` = 0x0000_0120 → stall/bubble cycle, one IRQ_ACK cycle, then TRAP with `trap_take_o` = 1, `pc_sel_o` = 10, `epc_o` = 0x120.
- `wfi_i` at `id_pc_i` = 0xFFFF_FFFC, `irq_i` raised 5 cycles later → `sleep_o` high 5 cycles, then `trap_take_o` with `epc_o` = 0x0000_0000 (wrap).
- `mem_stall_i` held 3 cycles during TRAP → all stalls 1 and `trap_take_o` = 0 for 3 cycles; then a single `trap_take_o` pulse.
- `mret_i` with `irq_i` both high → irq wins (IRQ_ACK), with `pc_sel_o` never 11 in that cycle.
